// File: rtl/rcvfifo_mc_pkg.sv
// Shared constants, write-FSM state encoding and helpers for the block-framed
// multi-channel receive FIFO.
package rcvfifo_mc_pkg;

  localparam logic [15:0] CH_COMMA = 16'h00BC;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2,
    ST_DROP = 2'd3
  } wst_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rcvfifo_chan.sv
// One receive channel: halfword packer FSM, speculative/committed/read pointers,
// block RAM and saturating drop counter.
module rcvfifo_chan
  import rcvfifo_mc_pkg::*;
#(
  parameter int          MBITS  = 10,
  parameter logic [15:0] FILLER = 16'h7FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dat,
  input  logic        vld,
  input  logic        pop,
  input  logic        chrst,
  input  logic        stclr,
  output logic [31:0] rdata,
  output logic [15:0] fifocnt,
  output logic [15:0] drop_cnt,
  output logic        nempty,
  output logic        dropped
);

  localparam int DEPTH = 2 ** MBITS;

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_q;
  logic [31:0]      r_byp_dat;
  logic             r_byp;
  logic [MBITS-1:0] r_waddr;
  logic [MBITS-1:0] r_caddr;
  logic [MBITS-1:0] r_raddr;
  logic [15:0]      r_lo;
  logic [15:0]      r_drop_cnt;
  logic             r_dropped;
  wst_e             r_state;

  logic             w_eob;
  logic             w_full;
  logic             w_odd_ev;
  logic             w_wr;
  logic             w_drop;
  logic [31:0]      w_wdat;
  logic [MBITS-1:0] w_waddr1;
  logic [MBITS-1:0] w_raddr_next;
  logic [MBITS-1:0] w_cnt;

  assign w_eob    = ~vld & (dat == CH_COMMA);
  assign w_waddr1 = r_waddr + 1'b1;
  // Uses the pre-pop read pointer, so a same-cycle pop can only make this pessimistic.
  assign w_full   = (w_waddr1 == r_raddr);
  assign w_odd_ev = (r_state == ST_ODD) & (vld | w_eob) & ~chrst;
  assign w_wr     = w_odd_ev & ~w_full;
  assign w_drop   = w_odd_ev & w_full;
  assign w_wdat   = vld ? {dat, r_lo} : {FILLER, r_lo};

  assign w_raddr_next = chrst ? '0 : (pop ? r_raddr + 1'b1 : r_raddr);

  assign w_cnt    = r_caddr - r_raddr;
  assign fifocnt  = 16'(w_cnt);
  assign nempty   = (r_caddr != r_raddr);
  assign drop_cnt = r_drop_cnt;
  assign dropped  = r_dropped;

  // The RAM is read at the pointer's next value so r_q always tracks mem[raddr];
  // the bypass covers a word written to that same address on the same edge.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_waddr] <= w_wdat;
    end
    r_q <= r_mem[w_raddr_next];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byp     <= 1'b0;
      r_byp_dat <= '0;
    end else begin
      r_byp     <= w_wr & (r_waddr == w_raddr_next);
      r_byp_dat <= w_wdat;
    end
  end

  assign rdata = r_byp ? r_byp_dat : r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_DROP;
      r_waddr <= '0;
      r_caddr <= '0;
      r_raddr <= '0;
      r_lo    <= '0;
    end else if (chrst) begin
      r_state <= ST_DROP;
      r_waddr <= '0;
      r_caddr <= '0;
      r_raddr <= '0;
    end else begin
      r_raddr <= w_raddr_next;
      unique case (r_state)
        ST_IDLE: begin
          if (vld) begin
            r_lo    <= dat;
            r_state <= ST_ODD;
          end
        end
        ST_EVEN: begin
          if (vld) begin
            r_lo    <= dat;
            r_state <= ST_ODD;
          end else if (w_eob) begin
            r_caddr <= r_waddr;
            r_state <= ST_IDLE;
          end
        end
        ST_ODD: begin
          if (w_full && (vld || w_eob)) begin
            r_waddr <= r_caddr;
            r_state <= ST_DROP;
          end else if (vld) begin
            r_waddr <= w_waddr1;
            r_state <= ST_EVEN;
          end else if (w_eob) begin
            r_waddr <= w_waddr1;
            r_caddr <= w_waddr1;
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_eob) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
      r_dropped  <= 1'b0;
    end else if (stclr) begin
      r_drop_cnt <= '0;
      r_dropped  <= 1'b0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
      r_dropped  <= 1'b1;
    end
  end

endmodule

// File: rtl/rcvfifo_mc.sv
// Multi-channel block-framed receive FIFO: NCH packing channels behind a
// Wishbone slave with DATA (pop on read / channel reset on write) and STATUS registers.
module rcvfifo_mc
  import rcvfifo_mc_pkg::*;
#(
  parameter  int          NCH    = 2,
  parameter  int          MBITS  = 10,
  parameter  logic [15:0] FILLER = 16'h7FFF,
  localparam int          CHBITS = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              wb_clk,
  input  logic              reset,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [CHBITS:0]   wb_adr,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack,
  input  logic [16*NCH-1:0] ch_dat,
  input  logic [NCH-1:0]    ch_vld,
  output logic [NCH-1:0]    nempty,
  output logic [NCH-1:0]    dropped
);

  localparam int NSLOT = 2 ** CHBITS;

  logic              r_ack;
  logic [31:0]       r_dat;
  logic              w_acc;
  logic              w_reg;
  logic [CHBITS-1:0] w_sel;
  logic [31:0]       w_rd;
  logic [31:0]       w_rdata   [NSLOT];
  logic [15:0]       w_fifocnt [NSLOT];
  logic [15:0]       w_dcnt    [NSLOT];
  logic [NSLOT-1:0]  w_nempty;

  assign w_acc = wb_cyc & wb_stb & ~r_ack;
  assign w_reg = wb_adr[0];
  assign w_sel = wb_adr[CHBITS:1];

  // Slots past NCH read as zero and have no strobes, which makes unmapped channels harmless.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_ch
      if (gi < NCH) begin : g_real
        logic w_hit;
        assign w_hit = w_acc & (w_sel == CHBITS'(gi));

        rcvfifo_chan #(
          .MBITS (MBITS),
          .FILLER(FILLER)
        ) u_chan (
          .clk     (wb_clk),
          .reset   (reset),
          .dat     (ch_dat[16*gi +: 16]),
          .vld     (ch_vld[gi]),
          .pop     (w_hit & ~wb_we & (w_reg == REG_DATA) & w_nempty[gi]),
          .chrst   (w_hit & wb_we & (w_reg == REG_DATA)),
          .stclr   (w_hit & wb_we & (w_reg == REG_STATUS)),
          .rdata   (w_rdata[gi]),
          .fifocnt (w_fifocnt[gi]),
          .drop_cnt(w_dcnt[gi]),
          .nempty  (w_nempty[gi]),
          .dropped (dropped[gi])
        );
      end else begin : g_pad
        assign w_rdata[gi]   = '0;
        assign w_fifocnt[gi] = '0;
        assign w_dcnt[gi]    = '0;
        assign w_nempty[gi]  = 1'b0;
      end
    end
  endgenerate

  assign nempty = w_nempty[NCH-1:0];

  always_comb begin
    w_rd = '0;
    if (w_reg == REG_STATUS) begin
      w_rd = {w_dcnt[w_sel], w_fifocnt[w_sel]};
    end else if (w_nempty[w_sel]) begin
      w_rd = w_rdata[w_sel];
    end
  end

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc & ~wb_we) ? w_rd : 32'd0;
    end
  end

  assign wb_ack   = r_ack;
  assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_rcvfifo_mc.sv
// Self-checking bench for rcvfifo_mc (NCH=3, MBITS=4) against a block-level
// queue model of committed words, drop counts and channel drop state.
module tb_rcvfifo_mc;

  localparam int NCH  = 3;
  localparam int USE  = 15;

  logic        clk;
  logic        reset;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  adr;
  logic [31:0] dat_o;
  logic        ack;
  logic [47:0] ch_dat;
  logic [2:0]  ch_vld;
  logic [2:0]  nempty;
  logic [2:0]  dropped;

  int total = 0;
  int bad   = 0;

  logic [16:0] sq    [NCH][$];
  logic [31:0] mq    [NCH][$];
  logic [15:0] mblk  [NCH][$];
  bit          mdrop [NCH];
  logic [15:0] mdcnt [NCH];
  bit          mdropped [NCH];

  rcvfifo_mc #(.NCH(3), .MBITS(4), .FILLER(16'h7FFF)) dut (
    .wb_clk  (clk),
    .reset   (reset),
    .wb_cyc  (cyc),
    .wb_stb  (stb),
    .wb_we   (we),
    .wb_adr  (adr),
    .wb_dat_o(dat_o),
    .wb_ack  (ack),
    .ch_dat  (ch_dat),
    .ch_vld  (ch_vld),
    .nempty  (nempty),
    .dropped (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_sym(input int c, input logic [16:0] s);
    int nw;
    logic [15:0] lo, hi;
    if (s[16]) begin
      if (!mdrop[c]) begin
        nw = (mblk[c].size() + 1) / 2;
        if (mq[c].size() + nw <= USE) begin
          for (int i = 0; i < nw; i++) begin
            lo = mblk[c][2*i];
            hi = (2*i + 1 < mblk[c].size()) ? mblk[c][2*i+1] : 16'h7FFF;
            mq[c].push_back({hi, lo});
          end
        end else begin
          if (mdcnt[c] != 16'hFFFF) mdcnt[c]++;
          mdropped[c] = 1'b1;
        end
      end
      mdrop[c] = 1'b0;
      mblk[c].delete();
    end else if (!mdrop[c]) begin
      mblk[c].push_back(s[15:0]);
    end
  endfunction

  task automatic tick();
    logic [16:0] s;
    for (int c = 0; c < NCH; c++) begin
      if (sq[c].size() > 0) begin
        s = sq[c].pop_front();
        ch_vld[c] = ~s[16];
        ch_dat[16*c +: 16] = s[16] ? 16'h00BC : s[15:0];
        model_sym(c, s);
      end else begin
        ch_vld[c] = 1'b0;
        ch_dat[16*c +: 16] = 16'h0000;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit busy();
    return (sq[0].size() + sq[1].size() + sq[2].size()) != 0;
  endfunction

  task automatic drain();
    for (int i = 0; i < 400 && busy(); i++) tick();
    chk("drain_done", {31'd0, busy()}, 32'd0);
    tick();
  endtask

  task automatic send(input int c, input int n);
    for (int i = 0; i < n; i++) sq[c].push_back({1'b0, 16'($urandom)});
    sq[c].push_back(17'h10000);
  endtask

  task automatic wb_access(input int c, input bit r, input bit w, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {c[1:0], r};
    chk("ack_before", {31'd0, ack}, 32'd0);
    tick();
    d = dat_o;
    chk("ack_high", {31'd0, ack}, 32'd1);
    if (w && c < NCH) begin
      if (!r) begin
        mq[c].delete(); mblk[c].delete(); mdrop[c] = 1'b1;
      end else begin
        mdcnt[c] = 16'd0; mdropped[c] = 1'b0;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    chk("ack_after", {31'd0, ack}, 32'd0);
  endtask

  task automatic rd_data(input int c, output logic [31:0] d);
    logic [31:0] exp;
    exp = 32'd0;
    if (c < NCH && mq[c].size() > 0) exp = mq[c].pop_front();
    wb_access(c, 1'b0, 1'b0, d);
    chk($sformatf("data_ch%0d", c), d, exp);
  endtask

  task automatic rd_status(input int c, output logic [31:0] d);
    logic [31:0] exp;
    exp = (c < NCH) ? {mdcnt[c], 16'(mq[c].size())} : 32'd0;
    wb_access(c, 1'b1, 1'b0, d);
    chk($sformatf("status_ch%0d", c), d, exp);
  endtask

  task automatic rd_all(input int c);
    logic [31:0] d;
    for (int i = 0; i < 20 && mq[c].size() > 0; i++) rd_data(c, d);
    rd_data(c, d);
  endtask

  task automatic chk_flags(input string tag);
    logic [2:0] en, ed;
    for (int c = 0; c < NCH; c++) begin
      en[c] = (mq[c].size() != 0);
      ed[c] = mdropped[c];
    end
    chk({tag, "_nempty"}, {29'd0, nempty}, {29'd0, en});
    chk({tag, "_dropped"}, {29'd0, dropped}, {29'd0, ed});
  endtask

  initial begin
    logic [31:0] d;
    int n;
    for (int c = 0; c < NCH; c++) begin
      mdrop[c] = 1'b1; mdcnt[c] = 16'd0; mdropped[c] = 1'b0;
    end
    cyc = 0; stb = 0; we = 0; adr = '0; ch_dat = '0; ch_vld = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_nempty", {29'd0, nempty}, 32'd0);
    chk("rst_dropped", {29'd0, dropped}, 32'd0);
    reset = 1'b0;
    tick();

    // Channels start in DROP: ch0's first block is discarded up to its comma.
    sq[0].push_back({1'b0, 16'hDEAD}); sq[0].push_back({1'b0, 16'hBEEF});
    sq[0].push_back(17'h10000);
    sq[1].push_back(17'h10000); sq[2].push_back(17'h10000);
    drain();
    chk_flags("post_reset");

    // Even block
    sq[0].push_back({1'b0, 16'h1111}); sq[0].push_back({1'b0, 16'h2222});
    sq[0].push_back({1'b0, 16'h3333}); sq[0].push_back({1'b0, 16'h4444});
    sq[0].push_back(17'h10000);
    drain();
    chk_flags("even");
    rd_status(0, d); chk("even_status", d, 32'h00000002);
    rd_data(0, d);   chk("even_w0", d, 32'h22221111);
    rd_data(0, d);   chk("even_w1", d, 32'h44443333);
    rd_data(0, d);   chk("even_empty", d, 32'h0);

    // Odd block gets the filler halfword
    sq[1].push_back({1'b0, 16'hA1A1}); sq[1].push_back({1'b0, 16'hB2B2});
    sq[1].push_back({1'b0, 16'hC3C3}); sq[1].push_back(17'h10000);
    drain();
    rd_data(1, d);   chk("odd_w0", d, 32'hB2B2A1A1);
    rd_data(1, d);   chk("odd_w1", d, 32'h7FFFC3C3);
    rd_status(0, d); chk("odd_ch0", d, 32'h0);

    // Overflow
    for (int b = 0; b < 5; b++) send(0, 4);
    drain();
    rd_status(0, d); chk("ovf_pre", d, 32'h0000000A);
    send(0, 20);
    drain();
    rd_status(0, d); chk("ovf_status", d, 32'h0001000A);
    chk("ovf_dropped", {31'd0, dropped[0]}, 32'd1);
    send(0, 2);
    drain();
    rd_status(0, d); chk("ovf_next", d, 32'h0001000B);
    wb_access(0, 1'b1, 1'b1, d);
    chk_flags("stclr");
    rd_status(0, d); chk("stclr_status", d, 32'h0000000B);
    rd_all(0);

    // Wrap with random blocks and reads overlapping the link traffic
    for (int b = 0; b < 50; b++) begin
      for (int i = 0; i < 20 && mq[2].size() > 8; i++) rd_data(2, d);
      n = $urandom_range(1, 7);
      send(2, n);
      repeat ($urandom_range(0, 2)) rd_data(2, d);
      drain();
      if (b % 10 == 9) rd_status(2, d);
    end
    rd_status(2, d);
    chk("wrap_nodrop", {16'd0, d[31:16]}, 32'd0);
    chk_flags("wrap");
    rd_all(2);

    // Mid-block channel reset on ch0 while ch1 streams
    send(0, 8);
    send(1, 12);
    repeat (3) tick();
    wb_access(0, 1'b0, 1'b1, d);
    rd_status(0, d); chk("chrst_cnt", d, 32'h0);
    drain();
    rd_status(0, d); chk("chrst_after", d, 32'h0);
    send(0, 4);
    drain();
    chk_flags("chrst");
    rd_all(0);
    rd_all(1);

    // Unmapped channel and empty reads
    rd_data(3, d);   chk("badch_data", d, 32'h0);
    rd_status(3, d); chk("badch_status", d, 32'h0);
    wb_access(3, 1'b0, 1'b1, d);
    rd_data(2, d);   chk("empty_data", d, 32'h0);
    rd_status(2, d); chk("empty_status", d, 32'h0);
    send(2, 2);
    drain();
    rd_status(2, d); chk("empty_then_one", d, 32'h00000001);
    rd_all(2);
    chk_flags("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
